// File: rtl/context_map_pipe_pkg.sv
// Shared widths, thresholds, context constants and stage payload types for context_map_pipe.
// Combinational definitions only; no latency, no backpressure.
package context_map_pipe_pkg;

  localparam int GRAD_WIDTH      = 10;
  localparam int MODE_LENGTH     = 2;
  localparam int MAPPEDQ_LENGTH  = 9;
  localparam int CHANNELS        = 3;
  localparam int CH_WIDTH        = 2;
  localparam int ADDR_WIDTH      = 11;

  localparam int T1_DEF          = 3;
  localparam int T2_DEF          = 7;
  localparam int T3_DEF          = 21;
  localparam int NEAR_DEF        = 0;

  localparam int RUN_CTX_BASE    = 365;
  localparam int CTX_PER_CHANNEL = 367;

  typedef logic signed [GRAD_WIDTH-1:0] grad_t;
  typedef logic signed [3:0]            q_t;
  typedef logic [MODE_LENGTH-1:0]       mode_t;
  typedef logic [MAPPEDQ_LENGTH-1:0]    ctx_t;
  typedef logic [CH_WIDTH-1:0]          ch_t;
  typedef logic [ADDR_WIDTH-1:0]        addr_t;

  localparam mode_t MODE_REGULAR = 2'd0;
  localparam mode_t MODE_RUNINT  = 2'd1;

  typedef struct packed {
    q_t    q1;
    q_t    q2;
    q_t    q3;
    mode_t mode;
    logic  ritype;
    ch_t   ch;
  } s1_t;

  typedef struct packed {
    ctx_t ct;
    logic sign;
    logic run_start;
    ch_t  ch;
  } s2_t;

  typedef struct packed {
    ctx_t  ct;
    logic  sign;
    logic  run_start;
    ch_t   ch;
    addr_t addr;
  } s3_t;

  // Channel values outside 0..CHANNELS-1 are deliberately not clamped.
  function automatic addr_t ctx_addr_f(ch_t ch, ctx_t ct);
    return addr_t'(int'(ch) * CTX_PER_CHANNEL + int'(ct));
  endfunction

endpackage

// File: rtl/context_map_pipe_if.sv
// Input gradient stream and output context stream of context_map_pipe, valid/ready on both sides.
// master = producer/consumer around the block, slave = the block itself.
interface context_map_pipe_if;
  import context_map_pipe_pkg::*;

  logic  in_valid;
  logic  in_ready;
  grad_t D_1;
  grad_t D_2;
  grad_t D_3;
  mode_t mode;
  logic  RIType;
  ch_t   channel;

  logic  out_valid;
  logic  out_ready;
  ctx_t  C_t;
  logic  sign;
  logic  run_start;
  ch_t   out_channel;
  addr_t ctx_addr;

  modport master (
    output in_valid, D_1, D_2, D_3, mode, RIType, channel, out_ready,
    input  in_ready, out_valid, C_t, sign, run_start, out_channel, ctx_addr
  );

  modport slave (
    input  in_valid, D_1, D_2, D_3, mode, RIType, channel, out_ready,
    output in_ready, out_valid, C_t, sign, run_start, out_channel, ctx_addr
  );

endinterface

// File: rtl/context_map_pipe_gradient_quantizer.sv
// Maps one signed local gradient onto the 9-level region index -4..4; purely combinational.
// No latency, no backpressure.
module gradient_quantizer
  import context_map_pipe_pkg::*;
#(
  parameter int T1   = T1_DEF,
  parameter int T2   = T2_DEF,
  parameter int T3   = T3_DEF,
  parameter int NEAR = NEAR_DEF
) (
  input  grad_t d,
  output q_t    q
);

  int dv;

  always_comb begin
    dv = int'(d);
    if      (dv <= -T3)   q = q_t'(-4);
    else if (dv <= -T2)   q = q_t'(-3);
    else if (dv <= -T1)   q = q_t'(-2);
    else if (dv <  -NEAR) q = q_t'(-1);
    else if (dv <=  NEAR) q = q_t'(0);
    else if (dv <   T1)   q = q_t'(1);
    else if (dv <   T2)   q = q_t'(2);
    else if (dv <   T3)   q = q_t'(3);
    else                  q = q_t'(4);
  end

endmodule

// File: rtl/context_map_pipe.sv
// Gradients -> quantize (S1) -> sign merge / context index (S2) -> per-channel RAM address (S3); 3-cycle latency, 1 sample/cycle.
// Backpressure: each stage holds while its successor is full and stalled; in_ready is combinational from out_ready only.
module context_map_pipe
  import context_map_pipe_pkg::*;
#(
  parameter int T1   = T1_DEF,
  parameter int T2   = T2_DEF,
  parameter int T3   = T3_DEF,
  parameter int NEAR = NEAR_DEF
) (
  input logic               clk,
  input logic               reset,
  context_map_pipe_if.slave bus
);

  q_t  q1_c, q2_c, q3_c;

  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic out_vld_q, out_vld_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  s3_t  out_q, out_d;

  logic s1_en, s2_en, s3_en;

  logic            neg;
  logic            regular;
  q_t              m1, m2, m3;
  logic signed [10:0] idx;
  s2_t             merged;

  gradient_quantizer #(.T1(T1), .T2(T2), .T3(T3), .NEAR(NEAR)) u_q1 (.d(bus.D_1), .q(q1_c));
  gradient_quantizer #(.T1(T1), .T2(T2), .T3(T3), .NEAR(NEAR)) u_q2 (.d(bus.D_2), .q(q2_c));
  gradient_quantizer #(.T1(T1), .T2(T2), .T3(T3), .NEAR(NEAR)) u_q3 (.d(bus.D_3), .q(q3_c));

  // A stage may load whenever it is empty or its content moves on this cycle.
  assign s3_en        = !out_vld_q || bus.out_ready;
  assign s2_en        = !s2_vld_q  || s3_en;
  assign s1_en        = !s1_vld_q  || s2_en;
  assign bus.in_ready = s1_en;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    if (s1_en) begin
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d = '{q1: q1_c, q2: q2_c, q3: q3_c, mode: bus.mode,
                 ritype: bus.RIType, ch: bus.channel};
      end
    end
  end

  always_comb begin
    neg = (s1_q.q1 < 0) ||
          (s1_q.q1 == 0 && s1_q.q2 < 0) ||
          (s1_q.q1 == 0 && s1_q.q2 == 0 && s1_q.q3 < 0);
    m1  = neg ? -s1_q.q1 : s1_q.q1;
    m2  = neg ? -s1_q.q2 : s1_q.q2;
    m3  = neg ? -s1_q.q3 : s1_q.q3;
    idx = 11'(81 * int'(m1) + 9 * int'(m2) + int'(m3));
    // Reserved mode encodings fall back to the regular path.
    regular = (s1_q.mode != MODE_RUNINT);
    merged  = '0;
    merged.ch = s1_q.ch;
    if (regular) begin
      merged.ct        = ctx_t'(idx);
      merged.sign      = neg;
      merged.run_start = (s1_q.q1 == 0) && (s1_q.q2 == 0) && (s1_q.q3 == 0);
    end else begin
      merged.ct        = ctx_t'(RUN_CTX_BASE) + ctx_t'(s1_q.ritype);
      merged.sign      = 1'b0;
      merged.run_start = 1'b0;
    end
  end

  always_comb begin
    s2_vld_d = s2_vld_q;
    s2_d     = s2_q;
    if (s2_en) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) s2_d = merged;
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_d     = out_q;
    if (s3_en) begin
      out_vld_d = s2_vld_q;
      if (s2_vld_q) begin
        out_d = '{ct: s2_q.ct, sign: s2_q.sign, run_start: s2_q.run_start,
                  ch: s2_q.ch, addr: ctx_addr_f(s2_q.ch, s2_q.ct)};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      out_vld_q <= out_vld_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      out_q     <= out_d;
    end
  end

  assign bus.out_valid   = out_vld_q;
  assign bus.C_t         = out_q.ct;
  assign bus.sign        = out_q.sign;
  assign bus.run_start   = out_q.run_start;
  assign bus.out_channel = out_q.ch;
  assign bus.ctx_addr    = out_q.addr;

endmodule
